// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam int DIV_ITER = 64;
  localparam int CNT_W    = $clog2(DIV_ITER);

  function automatic logic is_signed_op(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_quo_op(input div_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_fixup.sv
// Sign correction and quotient/remainder select applied in the FIX cycle.
module div_fixup
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  div_op_t          op,
  input  logic             neg_quo,
  input  logic             neg_rem,
  input  logic [XLEN-1:0]  quo,
  input  logic [XLEN-1:0]  rem,
  output logic [XLEN-1:0]  result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_DIV:  result = neg_quo ? -quo : quo;
      OP_DIVU: result = quo;
      // Remainder follows the dividend's sign.
      OP_REM:  result = neg_rem ? -rem : rem;
      OP_REMU: result = rem;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/int_divider.sv
// Multi-cycle 64-bit DIV/DIVU/REM/REMU unit, one quotient bit per cycle,
// result formatted for the register-file write port.
module int_divider
  import div_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  div_op_t         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [AW-1:0]   in_rd,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_data
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  div_op_t          op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;

  logic             acc_signed;
  logic             acc_sa, acc_sb;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    rem_diff;
  logic [XLEN-1:0]  fix_result;

  div_fixup #(.XLEN(XLEN)) u_fixup (
    .op      (op_q),
    .neg_quo (sign_a_q ^ sign_b_q),
    .neg_rem (sign_a_q),
    .quo     (quo_q),
    .rem     (rem_q),
    .result  (fix_result)
  );

  // The shifted partial remainder can reach 2*divisor-1, so compare at XLEN+1 bits.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  assign acc_signed = is_signed_op(in_op);
  assign acc_sa     = acc_signed & in_a[XLEN-1];
  assign acc_sb     = acc_signed & in_b[XLEN-1];

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !kill) begin
          op_d     = in_op;
          out_rd_d = in_rd;
          sign_a_d = acc_sa;
          sign_b_d = acc_sb;
          quo_d    = acc_sa ? -in_a : in_a;
          dvs_d    = acc_sb ? -in_b : in_b;
          if (in_b == '0) begin
            out_data_d  = is_quo_op(in_op) ? '1 : in_a;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (acc_signed && in_a == MIN_NEG && in_b == '1) begin
            out_data_d  = is_quo_op(in_op) ? in_a : '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = CNT_W'(DIV_ITER - 1);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], 1'b0};
          if (!rem_diff[XLEN]) begin
            rem_d    = rem_diff[XLEN-1:0];
            quo_d[0] = 1'b1;
          end else begin
            rem_d = rem_shift[XLEN-1:0];
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          out_data_d  = fix_result;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        // Kill takes priority over a simultaneous writeback handshake.
        if (kill || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_DIV;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_divider.sv
// Directed self-checking bench for int_divider with hand-computed results.
module tb_int_divider;
  import div_pkg::*;

  localparam int XLEN = 64;
  localparam int AW   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  div_op_t         in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [AW-1:0]   in_rd;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  int_divider #(.XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rd     (in_rd),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic issue(input div_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [AW-1:0] rd);
    int waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge (inclusive) to out_valid.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [63:0] exp_data, input logic [AW-1:0] exp_rd);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_rd"},   64'(out_rd), 64'(exp_rd));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input div_op_t op, input logic [63:0] a,
                     input logic [63:0] b, input logic [AW-1:0] rd,
                     input logic [63:0] exp_data, input int exp_lat);
    issue(op, a, b, rd);
    wait_result(tag, exp_lat, exp_data, rd);
    handshake(tag);
  endtask

  initial begin
    logic seen;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_DIV;
    in_a      = '0;
    in_b      = '0;
    in_rd     = '0;
    kill      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_rd",    64'(out_rd),    64'd0);
    check("rst_data",  out_data,       64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    run("divu_100_7",  OP_DIVU, 64'd100, 64'd7, 6'd17, 64'd14, 66);
    run("remu_100_7",  OP_REMU, 64'd100, 64'd7, 6'd18, 64'd2, 66);
    run("div_m7_2",    OP_DIV, -64'sd7, 64'd2, 6'd3, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run("rem_m7_2",    OP_REM, -64'sd7, 64'd2, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run("rem_7_m2",    OP_REM, 64'd7, -64'sd2, 6'd5, 64'd1, 66);
    run("div_m100_m7", OP_DIV, -64'sd100, -64'sd7, 6'd6, 64'd14, 66);
    run("rem_m100_m7", OP_REM, -64'sd100, -64'sd7, 6'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("divu_big",    OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 6'd8, 64'd1, 66);
    run("remu_big",    OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 6'd9, 64'd1, 66);
    run("remu_top",    OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 6'd10,
        64'h7FFF_FFFF_FFFF_FFFE, 66);
    run("div_5_0",     OP_DIV, 64'd5, 64'd0, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_5_0",    OP_REMU, 64'd5, 64'd0, 6'd12, 64'd5, 1);
    run("div_ovf",     OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd13,
        64'h8000_0000_0000_0000, 1);
    run("rem_ovf",     OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd14, 64'd0, 1);
    run("divu_minneg", OP_DIVU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd15, 64'd0, 66);

    // Backpressure: result and tag held, no new accept, then back-to-back issue.
    issue(OP_DIVU, 64'd100, 64'd7, 6'd9);
    wait_result("bp", 66, 64'd14, 6'd9);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data",  out_data, 64'd14);
      check("bp_rd",    64'(out_rd), 64'd9);
      check("bp_ready", 64'(in_ready), 64'd0);
    end
    handshake("bp");
    issue(OP_DIV, 64'd21, 64'd0, 6'd22);
    check("bp_next_busy", 64'(in_ready), 64'd0);
    wait_result("bp_next", 1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd22);
    handshake("bp_next");

    // Kill in IDLE together with an offer: not accepted.
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 64'd9; in_b = 64'd3; in_rd = 6'd1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_ready", 64'(in_ready), 64'd1);
    check("kill_idle_valid", 64'(out_valid), 64'd0);

    // Kill at CALC iteration 30.
    issue(OP_DIVU, 64'd100, 64'd7, 6'd2);
    repeat (29) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    check("kill_calc_no_result", 64'(seen), 64'd0);

    // Kill beats out_ready in DONE.
    issue(OP_DIV, 64'd5, 64'd0, 6'd3);
    check("kill_done_valid_pre", 64'(out_valid), 64'd1);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    check("kill_done_valid", 64'(out_valid), 64'd0);
    check("kill_done_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-CALC, after a result has left nonzero data behind.
    run("pre_rst", OP_DIVU, 64'd50, 64'd5, 6'd33, 64'd10, 66);
    issue(OP_DIVU, 64'd100, 64'd7, 6'd5);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_rd",    64'(out_rd),    64'd0);
    check("arst_data",  out_data,       64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run("post_rst", OP_REMU, 64'd100, 64'd7, 6'd44, 64'd2, 66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
